// File: rtl/noc_network_interface.sv
// noc_network_interface: core-side NoC endpoint packetizing spikes to the router and delivering received neuron addresses
// Ports:
//   clk, rst_n                               clock, synchronous active-low reset
//   router_addr                              own mesh address
//   spike_valid/ready, spike_dest_*          spike input from the core
//   net_out_packet/valid/ready               packets to the router local input
//   net_in_packet/valid/ready                packets from the router local output
//   rx_valid/ready, rx_neuron_addr           received neuron addresses to the core
//   tx_count, rx_count, drop_count           saturating traffic counters
module noc_network_interface #(
  parameter int ROUTER_ADDR_WIDTH = 4,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ROUTER_ADDR_WIDTH-1:0] router_addr,
  input  logic                         spike_valid,
  output logic                         spike_ready,
  input  logic [ROUTER_ADDR_WIDTH-1:0] spike_dest_router,
  input  logic [15:0]                  spike_dest_neuron,
  output logic [31:0]                  net_out_packet,
  output logic                         net_out_valid,
  input  logic                         net_out_ready,
  input  logic [31:0]                  net_in_packet,
  input  logic                         net_in_valid,
  output logic                         net_in_ready,
  output logic                         rx_valid,
  output logic [15:0]                  rx_neuron_addr,
  input  logic                         rx_ready,
  output logic [15:0]                  tx_count,
  output logic [15:0]                  rx_count,
  output logic [15:0]                  drop_count
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TCW = TAW + 1;
  localparam int RCW = RAW + 1;
  logic [31:0]    tx_mem [TX_DEPTH];
  logic [15:0]    rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wr, tx_rd;
  logic [RAW-1:0] rx_wr, rx_rd;
  logic [TCW-1:0] tx_cnt;
  logic [RCW-1:0] rx_cnt;
  logic           tx_push, tx_pop, rx_acc, rx_match, rx_push, rx_pop;
  logic [31:0]    tx_pkt;
  // Full/empty come from the registered occupancy only, so no input reaches a ready/valid combinationally
  assign spike_ready    = rst_n && (tx_cnt != TCW'(TX_DEPTH));
  assign net_out_valid  = rst_n && (tx_cnt != '0);
  assign net_in_ready   = rst_n && (rx_cnt != RCW'(RX_DEPTH));
  assign rx_valid       = rst_n && (rx_cnt != '0);
  assign net_out_packet = tx_mem[tx_rd];
  assign rx_neuron_addr = rx_mem[rx_rd];
  assign tx_pkt   = {spike_dest_router, {(16-ROUTER_ADDR_WIDTH){1'b0}}, spike_dest_neuron};
  assign tx_push  = spike_valid && spike_ready;
  assign tx_pop   = net_out_valid && net_out_ready;
  assign rx_acc   = net_in_valid && net_in_ready;
  assign rx_match = net_in_packet[31 -: ROUTER_ADDR_WIDTH] == router_addr;
  assign rx_push  = rx_acc && rx_match;
  assign rx_pop   = rx_valid && rx_ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Storage is cleared so the FWFT heads read zero until the first write
      for (int i = 0; i < TX_DEPTH; i++) tx_mem[i] <= '0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem[i] <= '0;
      tx_wr      <= '0;
      tx_rd      <= '0;
      tx_cnt     <= '0;
      rx_wr      <= '0;
      rx_rd      <= '0;
      rx_cnt     <= '0;
      tx_count   <= '0;
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr] <= tx_pkt;
        tx_wr         <= tx_wr + TAW'(1);
      end
      if (tx_pop) tx_rd <= tx_rd + TAW'(1);
      tx_cnt <= tx_cnt + TCW'(tx_push) - TCW'(tx_pop);
      if (rx_push) begin
        rx_mem[rx_wr] <= net_in_packet[15:0];
        rx_wr         <= rx_wr + RAW'(1);
      end
      if (rx_pop) rx_rd <= rx_rd + RAW'(1);
      rx_cnt <= rx_cnt + RCW'(rx_push) - RCW'(rx_pop);
      if (tx_pop && tx_count != 16'hFFFF) tx_count <= tx_count + 16'd1;
      if (rx_push && rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
      if (rx_acc && !rx_match && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
  end
endmodule
